data_sync_rx: RTL and testbench
===============================

// Module: data_sync_rx
// PURPOSE
//  Destination end of the 4-phase req/ack CDC handshake used for multi-bit control/data words.
//  Source domain holds req_data_i stable and raises req_i; this block synchronizes req_i into clk_dest.
//  It captures the word into a one-entry output buffer, presents it with valid/ready, and returns ack_o.
//  The source domain synchronizes ack_o back with its own 2-flop cell. Sits beside every ctrl sync on bus crossings.
// PARAMETERS
//  DW           8  width of req_data_i / dat_o
//  SYNC_STAGES  2  flops in req_i synchronizer chain; legal 2..4
// PORTS
//  clk_dest     in   1   destination clock
//  rst_dest_n   in   1   async active-low reset, clk_dest domain
//  req_i        in   1   request from source domain (asynchronous)
//  req_data_i   in   DW  source word; stable while req_i=1 and until ack_o seen low
//  ack_o        out  1   acknowledge to source domain, registered in clk_dest
//  dat_o        out  DW  captured word
//  dat_vld_o    out  1   dat_o valid
//  dat_rdy_i    in   1   consumer accepts dat_o when dat_vld_o & dat_rdy_i
// BEHAVIOUR
//  Reset (rst_dest_n=0, asynchronous): sync chain=0, state=IDLE, ack_o=0, dat_vld_o=0, dat_o=0.
//  req_s = last stage of SYNC_STAGES-flop chain on req_i; every flop resets to 0.
//  can_load = !dat_vld_o | dat_rdy_i (buffer empty or being drained this cycle).
//  FSM, 3 states:
//   IDLE: ack_o=0. req_s=1 & can_load -> load dat_o<=req_data_i, dat_vld_o<=1, ack_o<=1, go ACK.
//         req_s=1 & !can_load -> go HOLD.
//   HOLD: ack_o=0. Wait for can_load, then load as in IDLE and go ACK. A drop of req_s in HOLD is a
//         protocol violation: return to IDLE, no load.
//   ACK:  ack_o=1. req_s=0 -> ack_o<=0, go IDLE. The buffer may drain or hold meanwhile.
//  dat_vld_o clears on dat_vld_o & dat_rdy_i unless a load happens in the same cycle; load wins.
//  A simultaneous drain and load gives back-to-back valid with no bubble.
//  Latency: req_i rise to dat_vld_o=1 is SYNC_STAGES+1 clk_dest edges when the buffer is free.
//  ack_o rises the same edge as dat_vld_o.
//  req_i fall to ack_o fall: SYNC_STAGES+1 edges. Exactly one capture per req_i high phase.
//  req_data_i is sampled only on the load edge, never through the synchronizer.
//  Source stability guarantee: req_data_i is held stable through the load edge.
//  Reset mid-transfer: the buffered word is lost and ack_o drops.
//  If req_i is still high after reset release, the word is recaptured; the source tolerates a duplicate.
// CONFIGURATION
//  `DATA_SYNC_RX_PARITY_EN defined: adds port req_par_i (in, 1, even parity over req_data_i) and
//   port par_err_o (out, 1). On each load edge, par_err_o<=^{req_data_i,req_par_i}.
//   par_err_o is a 1-cycle pulse; it resets to 0. The word is still delivered.
//   req_par_i has the same stability rules as req_data_i.
//  Undefined: the ports and the parity logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package: state encoding typedef (IDLE=2'd0, HOLD=2'd1, ACK=2'd2) and SYNC_STAGES legal range constants.
//  Sub-module sync_ff: N-stage reset-to-0 bit synchronizer, used for req_i.
//  The source side reuses sync_ff for ack_o. FSM and buffer stay in this module.
// TESTING
//  1 Buffer empty, dat_rdy_i=1, req_i 0->1 with data 8'hA5
//    -> dat_vld_o & ack_o high at edge 3, dat_o=8'hA5.
//    req_i->0 -> ack_o low 3 edges later.
//  2 dat_rdy_i=0 holding word 8'h11; new req with 8'h22 -> FSM HOLD, ack_o=0, dat_o stays 8'h11.
//    Raise dat_rdy_i -> 8'h22 loads the same edge, no bubble.
//  3 req_i held high 20 cycles -> exactly one capture; ack_o stays 1 until req_i drops.
//  4 Assert rst_dest_n low while in ACK with dat_vld_o=1 -> all outputs 0 immediately (async).
//    req_i still high at release -> recapture after SYNC_STAGES+1 edges.
//  5 With DATA_SYNC_RX_PARITY_EN: data 8'h03 with req_par_i=1 -> par_err_o pulses 1 cycle.
//    req_par_i=0 -> no pulse.
//  6 Random async clk ratios 1:4..4:1, 1000 words -> the scoreboard shows in-order, no loss, no duplicates.

Source files
------------

// File: rtl/data_sync_rx_pkg.sv
// -----------------------------------------------------------------------------
// data_sync_rx_pkg
// Shared definitions for the destination side of the 4-phase req/ack
// crossing: the receive FSM state encoding and the legal range for the
// depth of the req synchronizer chain.
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package data_sync_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/data_sync_rx_if.sv
// -----------------------------------------------------------------------------
// data_sync_rx_if
// Bundles the request side (req_i / req_data_i / ack_o) and the consumer
// side (dat_o / dat_vld_o / dat_rdy_i) of data_sync_rx.
//   slave  : view of data_sync_rx itself
//   master : view of the source + consumer driving the block
// With `DATA_SYNC_RX_PARITY_EN defined, req_par_i (even parity over
// req_data_i) and par_err_o are added.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface data_sync_rx_if #(
    parameter int DW = 8
);
    logic          req_i;
    logic [DW-1:0] req_data_i;
    logic          ack_o;
    logic [DW-1:0] dat_o;
    logic          dat_vld_o;
    logic          dat_rdy_i;
`ifdef DATA_SYNC_RX_PARITY_EN
    logic          req_par_i;
    logic          par_err_o;
`endif

    modport slave (
        input  req_i,
        input  req_data_i,
        output ack_o,
        output dat_o,
        output dat_vld_o,
        input  dat_rdy_i
`ifdef DATA_SYNC_RX_PARITY_EN
        ,
        input  req_par_i,
        output par_err_o
`endif
    );

    modport master (
        output req_i,
        output req_data_i,
        input  ack_o,
        input  dat_o,
        input  dat_vld_o,
        output dat_rdy_i
`ifdef DATA_SYNC_RX_PARITY_EN
        ,
        output req_par_i,
        input  par_err_o
`endif
    );

endinterface

// File: rtl/data_sync_rx_sync_ff.sv
// -----------------------------------------------------------------------------
// data_sync_rx_sync_ff  (the sync_ff cell)
// N-stage single-bit synchronizer; every flop resets to 0. Used here for
// req_i and on the source side for ack_o.
// Ports:
//   clk    in  destination clock
//   rst_n  in  async active-low reset
//   d      in  asynchronous input bit
//   q      out synchronized bit (last stage of the chain)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_sync_rx_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/data_sync_rx.sv
// -----------------------------------------------------------------------------
// data_sync_rx
// Destination end of the 4-phase req/ack CDC handshake for multi-bit words.
// req_i is synchronized into clk_dest; when the synchronized request is
// seen and the one-entry output buffer can take a word, req_data_i is
// captured into dat_o, dat_vld_o is raised and ack_o is returned. ack_o
// falls once the synchronized request has fallen.
// Parameters:
//   DW           word width
//   SYNC_STAGES  depth of the req_i synchronizer (2..4)
// Ports:
//   clk_dest     in   destination clock
//   rst_dest_n   in   async active-low reset
//   bus          data_sync_rx_if.slave:
//     req_i, req_data_i in ; ack_o out ; dat_o, dat_vld_o out ; dat_rdy_i in
// Optional feature macro: DATA_SYNC_RX_PARITY_EN adds req_par_i / par_err_o;
// par_err_o pulses for one cycle when a loaded word fails even parity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_sync_rx
    import data_sync_rx_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_dest,
    input  logic          rst_dest_n,
    data_sync_rx_if.slave bus
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("data_sync_rx: SYNC_STAGES out of legal range");
    end

    logic          req_s;
    state_t        state;
    logic          ack_q;
    logic          vld_q;
    logic [DW-1:0] dat_q;
    logic          can_load;
    logic          do_load;
`ifdef DATA_SYNC_RX_PARITY_EN
    logic          par_err_q;
`endif

    data_sync_rx_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_dest),
        .rst_n (rst_dest_n),
        .d     (bus.req_i),
        .q     (req_s)
    );

    // Buffer is free, or its current word leaves on this edge.
    assign can_load = !vld_q || bus.dat_rdy_i;

    // A load only ever happens from IDLE or HOLD, so each req_i high phase
    // produces exactly one capture (ACK waits for req_s to fall).
    assign do_load  = req_s && can_load && (state == ST_IDLE || state == ST_HOLD);

    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            state     <= ST_IDLE;
            ack_q     <= 1'b0;
            vld_q     <= 1'b0;
            dat_q     <= '0;
`ifdef DATA_SYNC_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
`ifdef DATA_SYNC_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // Load wins over drain, giving back-to-back valid with no bubble.
            if (do_load) begin
                dat_q     <= bus.req_data_i;
                vld_q     <= 1'b1;
                ack_q     <= 1'b1;
`ifdef DATA_SYNC_RX_PARITY_EN
                par_err_q <= ^{bus.req_data_i, bus.req_par_i};
`endif
            end else if (vld_q && bus.dat_rdy_i) begin
                vld_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_s) begin
                        state <= can_load ? ST_ACK : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // req_s dropping here is a source protocol violation:
                    // abandon the transfer without loading.
                    if (!req_s) begin
                        state <= ST_IDLE;
                    end else if (can_load) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.dat_o     = dat_q;
    assign bus.dat_vld_o = vld_q;
`ifdef DATA_SYNC_RX_PARITY_EN
    assign bus.par_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_data_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_data_sync_rx
// Bench for data_sync_rx (DW=8, SYNC_STAGES=2). Directed cases cover reset,
// latency, back-pressure/HOLD, long requests, async reset mid-transfer and
// (with DATA_SYNC_RX_PARITY_EN) parity; then a randomized source on an
// independent clock sends words through the 4-phase handshake while a
// random consumer drains them against an in-order expected-word queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_sync_rx;

    localparam int DW      = 8;
    localparam int SS      = 2;
    localparam int LAT     = SS + 1;
    localparam int N_WORDS = 1000;

    logic clk_dest;
    logic clk_src;
    logic rst_dest_n;
    int   hp_dest = 5;
    int   hp_src  = 7;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] exp_q[$];
    logic          ack_s1 = 1'b0;
    logic          ack_s2 = 1'b0;

    data_sync_rx_if #(.DW(DW)) bus ();

    data_sync_rx #(
        .DW          (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_dest   (clk_dest),
        .rst_dest_n (rst_dest_n),
        .bus        (bus)
    );

    initial begin
        clk_dest = 1'b0;
        forever #(hp_dest) clk_dest = ~clk_dest;
    end

    initial begin
        clk_src = 1'b0;
        forever #(hp_src) clk_src = ~clk_src;
    end

    // Source-side 2-flop synchronizer for ack_o.
    always @(posedge clk_src) begin
        ack_s1 <= bus.ack_o;
        ack_s2 <= ack_s1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_dest);
        #1;
    endtask

    task automatic send_req(input logic [DW-1:0] d);
        @(negedge clk_dest);
        bus.req_data_i = d;
        bus.req_i      = 1'b1;
    endtask

    task automatic drop_req();
        @(negedge clk_dest);
        bus.req_i = 1'b0;
    endtask

    task automatic src_proc(input int n);
        int budget;
        for (int w = 0; w < n; w++) begin
            if (w % 100 == 0) begin
                hp_dest = $urandom_range(4, 16);
                hp_src  = $urandom_range(4, 16);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk_src);
            @(posedge clk_src);
            #1;
            bus.req_data_i = DW'($urandom);
`ifdef DATA_SYNC_RX_PARITY_EN
            bus.req_par_i  = ^bus.req_data_i;
`endif
            exp_q.push_back(bus.req_data_i);
            bus.req_i = 1'b1;
            budget = 0;
            while (!ack_s2 && budget < 400) begin
                @(posedge clk_src);
                #1;
                budget++;
            end
            if (!ack_s2) begin
                chk("rnd_ack_rise_timeout", 32'(ack_s2), 32'd1);
                bus.req_i = 1'b0;
                return;
            end
            bus.req_i = 1'b0;
            budget = 0;
            while (ack_s2 && budget < 400) begin
                @(posedge clk_src);
                #1;
                budget++;
            end
            if (ack_s2) begin
                chk("rnd_ack_fall_timeout", 32'(ack_s2), 32'd0);
                return;
            end
        end
    endtask

    task automatic cons_proc(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 60000) begin
            @(negedge clk_dest);
            cyc++;
            bus.dat_rdy_i = ($urandom_range(0, 9) < 7);
            // vld is stable until the next posedge, so this transfer will happen.
            if (bus.dat_vld_o && bus.dat_rdy_i) begin
                if (exp_q.size() == 0) chk("rnd_extra_word", 32'(bus.dat_o), 32'hFFFF_FFFF);
                else chk("rnd_word", 32'(bus.dat_o), 32'(exp_q.pop_front()));
                got++;
            end
        end
        chk("rnd_word_count", got, n);
    endtask

    int vld_cnt;

    initial begin
        rst_dest_n     = 1'b0;
        bus.req_i      = 1'b0;
        bus.req_data_i = '0;
        bus.dat_rdy_i  = 1'b1;
`ifdef DATA_SYNC_RX_PARITY_EN
        bus.req_par_i  = 1'b0;
`endif
        #1;
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_vld", 32'(bus.dat_vld_o), 32'd0);
        chk("rst_dat", 32'(bus.dat_o), 32'd0);
        tick(3);
        @(negedge clk_dest);
        rst_dest_n = 1'b1;
        tick(2);

        // Basic transfer with free buffer.
        send_req(8'hA5);
        tick(LAT - 1);
        chk("t1_vld_early", 32'(bus.dat_vld_o), 32'd0);
        chk("t1_ack_early", 32'(bus.ack_o), 32'd0);
        tick(1);
        chk("t1_vld", 32'(bus.dat_vld_o), 32'd1);
        chk("t1_ack", 32'(bus.ack_o), 32'd1);
        chk("t1_dat", 32'(bus.dat_o), 32'hA5);
        tick(1);
        chk("t1_drained", 32'(bus.dat_vld_o), 32'd0);
        drop_req();
        tick(LAT - 1);
        chk("t1_ack_hold", 32'(bus.ack_o), 32'd1);
        tick(1);
        chk("t1_ack_fall", 32'(bus.ack_o), 32'd0);

        // Back-pressure: second word waits in HOLD, then loads with no bubble.
        @(negedge clk_dest);
        bus.dat_rdy_i = 1'b0;
        send_req(8'h11);
        tick(LAT);
        chk("t2_dat11", 32'(bus.dat_o), 32'h11);
        drop_req();
        tick(LAT);
        chk("t2_ack0", 32'(bus.ack_o), 32'd0);
        send_req(8'h22);
        tick(LAT + 1);
        chk("t2_hold_ack", 32'(bus.ack_o), 32'd0);
        chk("t2_hold_dat", 32'(bus.dat_o), 32'h11);
        chk("t2_hold_vld", 32'(bus.dat_vld_o), 32'd1);
        @(negedge clk_dest);
        bus.dat_rdy_i = 1'b1;
        tick(1);
        chk("t2_load_dat", 32'(bus.dat_o), 32'h22);
        chk("t2_load_vld", 32'(bus.dat_vld_o), 32'd1);
        chk("t2_load_ack", 32'(bus.ack_o), 32'd1);
        drop_req();
        tick(1);
        chk("t2_drained", 32'(bus.dat_vld_o), 32'd0);
        tick(LAT - 1);
        chk("t2_ack_fall", 32'(bus.ack_o), 32'd0);

        // Long request: exactly one capture.
        send_req(8'h5C);
        vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.dat_vld_o) vld_cnt++;
        end
        chk("t3_one_capture", vld_cnt, 1);
        chk("t3_ack_held", 32'(bus.ack_o), 32'd1);
        chk("t3_dat", 32'(bus.dat_o), 32'h5C);
        drop_req();
        tick(LAT);
        chk("t3_ack_fall", 32'(bus.ack_o), 32'd0);

        // Async reset in ACK with a word buffered; recapture after release.
        @(negedge clk_dest);
        bus.dat_rdy_i = 1'b0;
        send_req(8'h77);
        tick(LAT);
        chk("t4_pre_vld", 32'(bus.dat_vld_o), 32'd1);
        #2;
        rst_dest_n = 1'b0;
        #1;
        chk("t4_rst_ack", 32'(bus.ack_o), 32'd0);
        chk("t4_rst_vld", 32'(bus.dat_vld_o), 32'd0);
        chk("t4_rst_dat", 32'(bus.dat_o), 32'd0);
        tick(2);
        @(negedge clk_dest);
        rst_dest_n    = 1'b1;
        bus.dat_rdy_i = 1'b1;
        tick(LAT - 1);
        chk("t4_rel_vld_early", 32'(bus.dat_vld_o), 32'd0);
        tick(1);
        chk("t4_recap_vld", 32'(bus.dat_vld_o), 32'd1);
        chk("t4_recap_dat", 32'(bus.dat_o), 32'h77);
        chk("t4_recap_ack", 32'(bus.ack_o), 32'd1);
        drop_req();
        tick(LAT);
        chk("t4_ack_fall", 32'(bus.ack_o), 32'd0);

`ifdef DATA_SYNC_RX_PARITY_EN
        // Parity: 8'h03 with req_par_i=1 is odd overall -> error pulse.
        @(negedge clk_dest);
        bus.req_par_i = 1'b1;
        send_req(8'h03);
        tick(LAT);
        chk("t5_perr_pulse", 32'(bus.par_err_o), 32'd1);
        chk("t5_perr_word", 32'(bus.dat_o), 32'h03);
        tick(1);
        chk("t5_perr_clear", 32'(bus.par_err_o), 32'd0);
        drop_req();
        tick(LAT);
        @(negedge clk_dest);
        bus.req_par_i = 1'b0;
        send_req(8'h03);
        tick(LAT);
        chk("t5_perr_none", 32'(bus.par_err_o), 32'd0);
        chk("t5_vld", 32'(bus.dat_vld_o), 32'd1);
        drop_req();
        tick(LAT);
`endif

        // Randomized clock ratios, random source gaps and consumer stalls.
        repeat (4) @(posedge clk_src);
        fork
            src_proc(N_WORDS);
            cons_proc(N_WORDS);
        join
        @(negedge clk_dest);
        bus.dat_rdy_i = 1'b1;
        tick(10);
        chk("rnd_queue_empty", exp_q.size(), 0);
        chk("rnd_no_extra_vld", 32'(bus.dat_vld_o), 32'd0);
        chk("rnd_ack_idle", 32'(bus.ack_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
